reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Debug read-out engine for the KGPminiRISC register-file probe port. It drives `reg_addr` into the core, waits for `final_res` to settle, and captures each value. It then streams (address, data) beats over a valid/ready interface to a logger or bench monitor. It sits beside the core at top level and replaces hand-written `reg_addr` stimulus.

## Interface
Parameters:
- `ADDR_W`, 5, width of the register address.
- `DATA_W`, 16, width of the register data.
- `SETTLE_CYCLES`, 1, number of cycles between a `reg_addr` change and `final_res` sampling; legal range ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first register to read; sampled with `start`.
- `num_regs`  in  ADDR_W+1  register count, 0..32; sampled with `start`.
- `reg_addr`  out  ADDR_W  probe address driven to the core.
- `final_res`  in  DATA_W  probe data returned by the core.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts the beat.
- `out_addr`  out  ADDR_W  register index of the beat.
- `out_data`  out  DATA_W  captured register value.
- `out_last`  out  1  marks the final beat of a dump.
- `busy`  out  1  high whenever the block is not in IDLE.
- `done`  out  1  one-cycle pulse when a dump completes.

## Operation
- FSM states: IDLE, SETTLE, EMIT, SUM (only when checksum is compiled in), DONE.
- IDLE, `start`=1, `num_regs`≠0: `reg_addr`←`start_addr`, remaining count←`num_regs`, settle counter←0, next state SETTLE.
- IDLE, `start`=1, `num_regs`=0: next state DONE with no beats emitted.
- SETTLE: the counter increments each cycle. On the edge where the counter reaches `SETTLE_CYCLES`-1:
  - `out_data`←`final_res`, `out_addr`←`reg_addr`.
  - `out_last`←(remaining==1) when checksum is compiled out; always 0 when it is compiled in.
  - `out_valid`←1; next state EMIT.
- EMIT: `out_*` hold stable while `out_valid`=1 and `out_ready`=0. `final_res` changes in this state are ignored.
- Handshake edge in EMIT (`out_valid`&`out_ready`): `out_valid`←0 and remaining decrements.
  - If beats remain: `reg_addr`←`reg_addr`+1, wrapping 31→0 modulo 2^ADDR_W; next state SETTLE.
  - Otherwise: next state SUM when checksum is compiled in, else DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored while `busy`=1.

## Timing
- Reset values: `reg_addr`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0, FSM in IDLE, checksum=0.
- Reset mid-dump aborts the dump immediately and asynchronously. No `done` pulse follows reset.
- Latency: the `start` edge is E0; `out_valid` rises at edge E0+`SETTLE_CYCLES`.
- Throughput: with `out_ready` held high, one beat every `SETTLE_CYCLES`+1 cycles.
- `done` rises on the edge after the last handshake (after the SUM handshake when checksum is enabled).
- `out_valid` never drops without a handshake. It is a registered output with no combinational path from `out_ready`.

## Configuration
- Macro: `REG_DUMP_CHECKSUM_EN`.
- Defined:
  - A 16-bit wrap-around sum of all emitted `out_data` values is accumulated during the dump, cleared on `start`.
  - After the last register beat, state SUM emits one extra beat: `out_data`=sum, `out_addr`=0, `out_last`=1. It uses the same hold-until-ready rule.
  - `num_regs`=0 emits a single SUM beat with data 0.
- Undefined: no SUM state and no accumulator. `out_last` marks the last register beat, and `num_regs`=0 emits nothing.

## Structure
- Shared package `reg_dump_pkg`: the FSM state enum, and the `ADDR_W`/`DATA_W` defaults as localparams.
- No sub-module. The settle counter, address incrementer and accumulator are small enough to stay inline.

## Test plan
- Core regs preloaded with r3=0x1234 and r4=0xABCD; `start_addr`=3, `num_regs`=2, `SETTLE_CYCLES`=1, ready high.
  - Required: beats (3,0x1234) and (4,0xABCD), `out_last` on the second beat, `done` 1 cycle later.
  - With `REG_DUMP_CHECKSUM_EN`: a third beat with data 0xBE01 and `out_last`=1.
- `start_addr`=30, `num_regs`=4: beat addresses are 30, 31, 0, 1 (wrap-around).
- `out_ready` held low 5 cycles on the first beat: `out_valid`, `out_addr` and `out_data` stay constant, and `reg_addr` does not advance.
- `rst` asserted in EMIT of the second beat: all outputs reach reset values without a clock edge, and a subsequent `start` dumps normally.
- `num_regs`=0: no register beats and `done` 1 cycle after `start`. A `start` pulse while `busy`=1 is ignored, so the beat count equals the original `num_regs`.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the register-dump read-out engine.
package reg_dump_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 16;
  localparam int SUM_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_EMIT   = 3'd2,
    ST_SUM    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Width of the settle counter; never below one bit.
  function automatic int cnt_width(input int settle_cycles);
    if (settle_cycles > 1) begin
      return $clog2(settle_cycles);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/reg_dump_reader.sv
// Drives reg_addr into the core probe port, samples final_res after settling and streams
// (addr, data) beats over valid/ready. Optional trailing checksum beat: REG_DUMP_CHECKSUM_EN.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   num_regs,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] final_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int               CNT_W    = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W:0]  REM_ONE  = (ADDR_W + 1)'(1);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W:0]     r_remaining;
  logic [ADDR_W-1:0]   r_reg_addr;
  logic                r_out_valid;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;
  logic                r_busy;
  logic                r_done;

  logic w_start;
  logic w_capture;
  logic w_settle_wait;
  logic w_hs_emit;
  logic w_more;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [SUM_W-1:0] r_sum;
  logic             w_sum_beat;
  logic             w_hs_sum;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (num_regs != '0) begin
            w_next = ST_SETTLE;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            w_next = ST_SUM;
`else
            w_next = ST_DONE;
`endif
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == CNT_LAST) begin
          w_next = ST_EMIT;
        end else begin
          w_next = ST_SETTLE;
        end
      end
      ST_EMIT: begin
        if (r_out_valid && out_ready) begin
          if (r_remaining > REM_ONE) begin
            w_next = ST_SETTLE;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            w_next = ST_SUM;
`else
            w_next = ST_DONE;
`endif
          end
        end else begin
          w_next = ST_EMIT;
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_SUM: begin
        if (r_out_valid && out_ready) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_SUM;
        end
      end
`endif
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM output decode: per-state strobes that steer the datapath registers.
  always_comb begin
    w_start       = 1'b0;
    w_capture     = 1'b0;
    w_settle_wait = 1'b0;
    w_hs_emit     = 1'b0;
    w_more        = (r_remaining > REM_ONE);
`ifdef REG_DUMP_CHECKSUM_EN
    w_sum_beat    = 1'b0;
    w_hs_sum      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_start = start;
`ifdef REG_DUMP_CHECKSUM_EN
        w_sum_beat = start && (num_regs == '0);
`endif
      end
      ST_SETTLE: begin
        if (r_cnt == CNT_LAST) begin
          w_capture = 1'b1;
        end else begin
          w_settle_wait = 1'b1;
        end
      end
      ST_EMIT: begin
        w_hs_emit = r_out_valid && out_ready;
`ifdef REG_DUMP_CHECKSUM_EN
        w_sum_beat = r_out_valid && out_ready && !w_more;
`endif
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_SUM: begin
        w_hs_sum = r_out_valid && out_ready;
      end
`endif
      default: begin
        w_start = 1'b0;
      end
    endcase
  end

  // Probe address, remaining count and settle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_addr  <= '0;
      r_remaining <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_start) begin
        r_remaining <= num_regs;
        r_cnt       <= '0;
        if (num_regs != '0) begin
          r_reg_addr <= start_addr;
        end
      end
      if (w_settle_wait) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_hs_emit) begin
        r_remaining <= r_remaining - REM_ONE;
        if (w_more) begin
          r_reg_addr <= r_reg_addr + ADDR_W'(1);
          r_cnt      <= '0;
        end
      end
    end
  end

  // Output beat registers; they only change on capture, handshake or the checksum beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_out_addr  <= r_reg_addr;
        r_out_data  <= final_res;
`ifdef REG_DUMP_CHECKSUM_EN
        r_out_last  <= 1'b0;
`else
        r_out_last  <= (r_remaining == REM_ONE);
`endif
      end
      if (w_hs_emit) begin
        r_out_valid <= 1'b0;
      end
`ifdef REG_DUMP_CHECKSUM_EN
      if (w_hs_sum) begin
        r_out_valid <= 1'b0;
      end
      // Sum beat overrides the handshake clear of the final register beat.
      if (w_sum_beat) begin
        r_out_valid <= 1'b1;
        r_out_addr  <= '0;
        r_out_last  <= 1'b1;
        r_out_data  <= (r_state == ST_IDLE) ? '0 : DATA_W'(r_sum);
      end
`endif
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  // Wrap-around checksum of every captured register value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (w_start) begin
      r_sum <= '0;
    end else if (w_capture) begin
      r_sum <= r_sum + SUM_W'(final_res);
    end
  end
`endif

  // Registered status flags, derived from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= (w_next == ST_DONE);
    end
  end

  assign reg_addr  = r_reg_addr;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Table-driven bench for reg_dump_reader with a behavioural register-file probe.
module tb_reg_dump_reader;

  localparam int CK =
`ifdef REG_DUMP_CHECKSUM_EN
    1;
`else
    0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  start_addr;
  logic [5:0]  num_regs;
  logic [4:0]  reg_addr;
  logic [15:0] final_res;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] regs [32];
  assign final_res = regs[reg_addr];

  always #5 clk = ~clk;

  reg_dump_reader #(.ADDR_W(5), .DATA_W(16), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .num_regs(num_regs),
    .reg_addr(reg_addr), .final_res(final_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  typedef struct {
    logic [4:0]  sa;
    logic [5:0]  n;
    bit          inj;
    logic [4:0]  a_first;
    logic [15:0] d_first;
    logic [4:0]  a_last;
    logic [15:0] d_last;
    logic [15:0] sum;
  } vec_t;

  vec_t vecs [7];

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  b_addr [64];
  logic [15:0] b_data [64];
  logic        b_last [64];
  int          b_cyc  [64];
  int          nb;
  int          done_cyc;
  logic        busy0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one dump with ready held high and record every accepted beat.
  task automatic run_dump(input logic [4:0] sa, input logic [5:0] n, input bit inj);
    int cyc;
    @(negedge clk);
    start = 1'b1; start_addr = sa; num_regs = n; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy0 = busy;
    cyc = 0; nb = 0; done_cyc = -1;
    while (cyc < 200 && done_cyc < 0) begin
      if (done) begin
        done_cyc = cyc;
      end else if (out_valid && out_ready && nb < 64) begin
        b_addr[nb] = out_addr; b_data[nb] = out_data; b_last[nb] = out_last; b_cyc[nb] = cyc;
        nb++;
      end
      if (inj && cyc == 2) begin
        start = 1'b1; start_addr = 5'd10; num_regs = 6'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic verify(input int idx, input vec_t v);
    int total;
    int exp_cyc;
    logic [4:0] ea;
    total = int'(v.n) + CK;
    check($sformatf("v%0d_busy", idx), {31'd0, busy0}, 32'd1);
    check($sformatf("v%0d_beats", idx), nb, total);
    for (int j = 0; j < nb; j++) begin
      if (j < int'(v.n)) begin
        ea = v.sa + 5'(j);
        exp_cyc = 1 + 2 * j;
        check($sformatf("v%0d_addr%0d", idx, j), {27'd0, b_addr[j]}, {27'd0, ea});
        check($sformatf("v%0d_data%0d", idx, j), {16'd0, b_data[j]}, {16'd0, regs[ea]});
      end else begin
        exp_cyc = 2 * int'(v.n);
        check($sformatf("v%0d_sumaddr", idx), {27'd0, b_addr[j]}, 32'd0);
        check($sformatf("v%0d_sumdata", idx), {16'd0, b_data[j]}, {16'd0, v.sum});
      end
      check($sformatf("v%0d_last%0d", idx, j), {31'd0, b_last[j]}, {31'd0, (j == total - 1)});
      check($sformatf("v%0d_cyc%0d", idx, j), b_cyc[j], exp_cyc);
    end
    if (v.n != 6'd0 && nb >= int'(v.n)) begin
      check($sformatf("v%0d_first_addr", idx), {27'd0, b_addr[0]}, {27'd0, v.a_first});
      check($sformatf("v%0d_first_data", idx), {16'd0, b_data[0]}, {16'd0, v.d_first});
      check($sformatf("v%0d_last_addr", idx), {27'd0, b_addr[v.n-1]}, {27'd0, v.a_last});
      check($sformatf("v%0d_last_data", idx), {16'd0, b_data[v.n-1]}, {16'd0, v.d_last});
    end
    if (total == 0) begin
      check($sformatf("v%0d_done_cyc", idx), done_cyc, 0);
    end else begin
      check($sformatf("v%0d_done_cyc", idx), done_cyc, b_cyc[nb-1] + 1);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_addr"}, {27'd0, out_addr}, 32'd0);
    check({tag, "_data"}, {16'd0, out_data}, 32'd0);
    check({tag, "_last"}, {31'd0, out_last}, 32'd0);
    check({tag, "_regaddr"}, {27'd0, reg_addr}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 32; i++) regs[i] = 16'hC000 | 16'(i);
    regs[3] = 16'h1234;
    regs[4] = 16'hABCD;

    vecs[0] = '{5'd3,  6'd2,  1'b0, 5'd3,  16'h1234, 5'd4,  16'hABCD, 16'hBE01};
    vecs[1] = '{5'd30, 6'd4,  1'b0, 5'd30, 16'hC01E, 5'd1,  16'hC001, 16'h003E};
    vecs[2] = '{5'd0,  6'd1,  1'b0, 5'd0,  16'hC000, 5'd0,  16'hC000, 16'hC000};
    vecs[3] = '{5'd31, 6'd1,  1'b0, 5'd31, 16'hC01F, 5'd31, 16'hC01F, 16'hC01F};
    vecs[4] = '{5'd0,  6'd32, 1'b0, 5'd0,  16'hC000, 5'd31, 16'hC01F, 16'h3FEA};
    vecs[5] = '{5'd0,  6'd0,  1'b0, 5'd0,  16'h0000, 5'd0,  16'h0000, 16'h0000};
    vecs[6] = '{5'd5,  6'd3,  1'b1, 5'd5,  16'hC005, 5'd7,  16'hC007, 16'h4012};

    rst = 1'b0; start = 1'b0; start_addr = 5'd0; num_regs = 6'd0; out_ready = 1'b1;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    for (int i = 0; i < 7; i++) begin
      run_dump(vecs[i].sa, vecs[i].n, vecs[i].inj);
      verify(i, vecs[i]);
    end

    // Back-pressure: first beat held for 5 cycles while the probed value changes.
    @(negedge clk);
    start = 1'b1; start_addr = 5'd3; num_regs = 6'd2; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    check("hold_valid_seen", {31'd0, out_valid}, 32'd1);
    regs[3] = 16'h5555;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold_valid%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("hold_addr%0d", c), {27'd0, out_addr}, 32'd3);
      check($sformatf("hold_data%0d", c), {16'd0, out_data}, 32'h1234);
      check($sformatf("hold_regaddr%0d", c), {27'd0, reg_addr}, 32'd3);
    end
    regs[3] = 16'h1234;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_after_hs_valid", {31'd0, out_valid}, 32'd0);
    check("hold_after_hs_regaddr", {27'd0, reg_addr}, 32'd4);
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    check("hold_beat2_addr", {27'd0, out_addr}, 32'd4);
    check("hold_beat2_data", {16'd0, out_data}, 32'hABCD);
    k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    check("hold_done", {31'd0, done}, 32'd1);

    // Asynchronous reset while the second beat waits in EMIT.
    @(negedge clk);
    start = 1'b1; start_addr = 5'd3; num_regs = 6'd2; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(out_valid && out_addr == 5'd4) && k < 20) begin @(negedge clk); k++; end
    out_ready = 1'b0;
    check("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b0;
    #1 check_idle_outputs("rst_mid");
    @(negedge clk);
    check("rst_no_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    run_dump(vecs[0].sa, vecs[0].n, 1'b0);
    verify(7, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
